// File: rtl/external_bus_interface_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : external_bus_interface_pkg
//  Purpose : Shared definitions for the external bus interface: FSM state
//            encoding, the NOP opcode that is presented to the core while no
//            valid read data exists, and the expected mux_oe values for each
//            bus direction.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package external_bus_interface_pkg;

    typedef enum logic [1:0] {
        EBI_IDLE    = 2'd0,
        EBI_CAPTURE = 2'd1,
        EBI_REQ     = 2'd2
    } ebi_state_t;

    localparam logic [7:0] c_NOP_OPCODE = 8'hEA;
    localparam logic [7:0] c_OE_READ    = 8'h00;
    localparam logic [7:0] c_OE_WRITE   = 8'hFF;

    // The core drives uio only on writes, so a read must show all-inputs and
    // a write all-outputs; anything else means the phase framing is broken.
    function automatic logic oe_mismatch(input logic rw, input logic [7:0] oe);
        return rw ? (oe != c_OE_READ) : (oe != c_OE_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/external_bus_interface_if.sv
`default_nettype none
// ============================================================================
//  Module  : external_bus_interface_if
//  Purpose : valid/ready memory request channel between the external bus
//            interface (master) and a memory (slave).
//  Signals : mem_valid  request pending
//            mem_we     1 = write
//            mem_addr   16-bit transaction address
//            mem_wdata  write data
//            mem_ready  memory accepts/completes the request
//            mem_rdata  read data, valid with mem_valid & mem_ready & ~mem_we
//  Rev     : 1.0  initial release
// ============================================================================
interface external_bus_interface_if;

    logic        mem_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/external_bus_interface_phase_detect.sv
`default_nettype none
// ============================================================================
//  Module  : external_bus_interface_phase_detect
//  Purpose : Registers the CPU phase level and produces single-clk rise/fall
//            pulses. phase is generated on clk, so no synchroniser is used.
//  Ports   : clk    fast system clock
//            rst_n  asynchronous active-low reset
//            phase  clk_cpu level
//            rise   phase & ~phase_q
//            fall   ~phase & phase_q
//  Rev     : 1.0  initial release
// ============================================================================
module external_bus_interface_phase_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic phase,
    output logic rise,
    output logic fall
);

    logic r_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_q <= 1'b0;
        end else begin
            r_phase_q <= phase;
        end
    end

    assign rise = phase & ~r_phase_q;
    assign fall = ~phase & r_phase_q;

endmodule
`default_nettype wire

// File: rtl/external_bus_interface.sv
`default_nettype none
// ============================================================================
//  Module  : external_bus_interface
//  Purpose : Rebuilds one 16-bit bus transaction per CPU cycle from the
//            time-multiplexed 6502 pin stream and issues it to memory over a
//            valid/ready handshake; read data is returned on cpu_rdata.
//  Ports   : clk, rst_n            fast clock, async active-low reset
//            phase                 clk_cpu level (0 = addr-lo/rw, 1 = addr-hi/data)
//            mux_addr/data/oe      core uo_out / uio_out / uio_oe
//            mem (master modport)  memory request channel
//            cpu_rdata             data to core uio_in
//            busy                  transaction outstanding
//            late_err              sticky: phase edge while transaction open
//            protocol_err          sticky: mux_oe inconsistent with rw
//            err_clr               synchronous clear of sticky errors
//            timeout_err           sticky timeout (EBI_TIMEOUT_EN only)
//  Config  : `define EBI_TIMEOUT_EN to abort requests that stay unanswered
//            for TIMEOUT_CYCLES clk.
//  Rev     : 1.0  initial release
// ============================================================================
module external_bus_interface
    import external_bus_interface_pkg::*;
#(
    parameter logic [7:0] RDATA_RESET = c_NOP_OPCODE
`ifdef EBI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 6
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           phase,
    input  logic [7:0]                     mux_addr,
    input  logic [7:0]                     mux_data,
    input  logic [7:0]                     mux_oe,
    external_bus_interface_if.master       mem,
    output logic [7:0]                     cpu_rdata,
    output logic                           busy,
    output logic                           late_err,
    output logic                           protocol_err,
`ifdef EBI_TIMEOUT_EN
    output logic                           timeout_err,
`endif
    input  logic                           err_clr
);

    logic       w_rise;
    logic       w_fall;
    logic [7:0] r_lo_addr;
    logic       r_rw;
    ebi_state_t r_state;

`ifdef EBI_TIMEOUT_EN
    localparam int         c_TMO_W    = 8;
    localparam logic [7:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0]    r_tmo_cnt;
`endif

    external_bus_interface_phase_detect u_phase_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Low-phase sampler: the last sample before phase rises is the one the
    // transaction uses, which tolerates pins settling late in the low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_addr <= 8'h00;
            r_rw      <= 1'b0;
        end else if (!phase) begin
            r_lo_addr <= mux_addr;
            r_rw      <= mux_data[0];
        end
    end

    // Error-flag updates are written after the err_clr clear so that a new
    // error event in the same clk overrides the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= EBI_IDLE;
            mem.mem_valid  <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 16'h0000;
            mem.mem_wdata  <= 8'h00;
            cpu_rdata      <= RDATA_RESET;
            busy           <= 1'b0;
            late_err       <= 1'b0;
            protocol_err   <= 1'b0;
`ifdef EBI_TIMEOUT_EN
            timeout_err    <= 1'b0;
            r_tmo_cnt      <= '0;
`endif
        end else begin
            if (err_clr) begin
                late_err     <= 1'b0;
                protocol_err <= 1'b0;
`ifdef EBI_TIMEOUT_EN
                timeout_err  <= 1'b0;
`endif
            end

            case (r_state)
                EBI_IDLE: begin
                    if (w_rise) begin
                        r_state <= EBI_CAPTURE;
                    end
                end

                EBI_CAPTURE: begin
                    mem.mem_addr  <= {mux_addr, r_lo_addr};
                    mem.mem_we    <= ~r_rw;
                    mem.mem_wdata <= r_rw ? 8'h00 : mux_data;
                    mem.mem_valid <= 1'b1;
                    busy          <= 1'b1;
                    r_state       <= EBI_REQ;
`ifdef EBI_TIMEOUT_EN
                    r_tmo_cnt     <= '0;
`endif
                    if (oe_mismatch(r_rw, mux_oe)) begin
                        protocol_err <= 1'b1;
                    end
                    // Only possible with a one-clk high phase.
                    if (w_fall) begin
                        late_err <= 1'b1;
                    end
                end

                EBI_REQ: begin
                    // A phase edge here means the core has moved on before the
                    // memory answered; a rising edge's new cycle is dropped
                    // because IDLE will not see that rise again.
                    if (w_fall || w_rise) begin
                        late_err <= 1'b1;
                    end
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        busy          <= 1'b0;
                        if (!mem.mem_we) begin
                            cpu_rdata <= mem.mem_rdata;
                        end
                        r_state <= EBI_IDLE;
                    end
`ifdef EBI_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        mem.mem_valid <= 1'b0;
                        busy          <= 1'b0;
                        if (!mem.mem_we) begin
                            cpu_rdata <= c_NOP_OPCODE;
                        end
                        timeout_err <= 1'b1;
                        r_state     <= EBI_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state <= EBI_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
